fetch_queue: RTL and testbench

Parametrised, decoupling instruction buffer between the fetch stage and decode in the frontend. It accepts up to ENQ_WIDTH fetched instructions per cycle under a per-slot valid mask and compacts them in slot order. It stores them with their PCs in a circular buffer and presents up to DEQ_WIDTH oldest entries per cycle to decode, which consumes a variable count. The queue flushes completely on a misprediction, so fetch can run ahead of decode and stalls do not ripple through the frontend.

---
 rtl/fetch_queue_pkg.sv | 21 ++
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue_compact.sv | 32 +++
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the frontend fetch queue.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH       = 16;
    localparam int unsigned FQ_INSTR_WIDTH = 32;

    typedef struct packed {
        logic [FQ_INSTR_WIDTH-1:0] instr;
        logic [63:0]               pc;
    } fq_entry_t;

    function automatic int unsigned fq_min3(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side enqueue and decode-side dequeue signals of the fetch queue.
interface fetch_queue_if import fetch_queue_pkg::*; #(
    parameter int unsigned INSTRUCTION_WIDTH = FQ_INSTR_WIDTH,
    parameter int unsigned ENQ_WIDTH         = 4,
    parameter int unsigned DEQ_WIDTH         = 4,
    parameter int unsigned DEPTH             = FQ_DEPTH
);
    localparam int unsigned TAKE_W  = $clog2(DEQ_WIDTH + 1);
    localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

    logic                                          flush_in;
    logic                                          enq_valid_in;
    logic [ENQ_WIDTH-1:0]                          enq_mask_in;
    logic [ENQ_WIDTH-1:0][INSTRUCTION_WIDTH-1:0]   enq_instr_in;
    logic [63:0]                                   enq_pc_in;
    logic                                          enq_ready_out;
    logic [TAKE_W-1:0]                             deq_take_in;
    logic [DEQ_WIDTH-1:0]                          deq_valid_out;
    logic [DEQ_WIDTH-1:0][INSTRUCTION_WIDTH-1:0]   deq_instr_out;
    logic [DEQ_WIDTH-1:0][63:0]                    deq_pc_out;
    logic [COUNT_W-1:0]                            count_out;
    logic                                          overflow_err_out;

    modport master (
        output flush_in, enq_valid_in, enq_mask_in, enq_instr_in, enq_pc_in, deq_take_in,
        input  enq_ready_out, deq_valid_out, deq_instr_out, deq_pc_out, count_out,
               overflow_err_out
    );

    modport slave (
        input  flush_in, enq_valid_in, enq_mask_in, enq_instr_in, enq_pc_in, deq_take_in,
        output enq_ready_out, deq_valid_out, deq_instr_out, deq_pc_out, count_out,
               overflow_err_out
    );

endinterface

// File: rtl/fetch_queue_compact.sv
// Packs the masked fetch slots to the low end in slot order and derives each slot's PC.
module fq_compact import fetch_queue_pkg::*; #(
    parameter int unsigned INSTRUCTION_WIDTH = FQ_INSTR_WIDTH,
    parameter int unsigned ENQ_WIDTH         = 4
) (
    input  logic [ENQ_WIDTH-1:0]                        mask_in,
    input  logic [ENQ_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic [63:0]                                 pc_in,
    output logic [ENQ_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] instr_out,
    output logic [ENQ_WIDTH-1:0][63:0]                  pc_out,
    output logic [$clog2(ENQ_WIDTH+1)-1:0]              count_out
);
    localparam int unsigned IDX_W = (ENQ_WIDTH > 1) ? $clog2(ENQ_WIDTH) : 1;
    localparam int unsigned CNT_W = $clog2(ENQ_WIDTH + 1);

    int unsigned n;

    always_comb begin
        instr_out = '0;
        pc_out    = '0;
        n         = 0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (mask_in[i]) begin
                instr_out[IDX_W'(n)] = instr_in[i];
                pc_out[IDX_W'(n)]    = pc_in + 64'(4 * i);
                n++;
            end
        end
        count_out = CNT_W'(n);
    end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer decoupling fetch from decode; flushes on misprediction.
module fetch_queue import fetch_queue_pkg::*; #(
    parameter int unsigned INSTRUCTION_WIDTH = FQ_INSTR_WIDTH,
    parameter int unsigned ENQ_WIDTH         = 4,
    parameter int unsigned DEQ_WIDTH         = 4,
    parameter int unsigned DEPTH             = FQ_DEPTH
) (
    input  logic          clk_in,
    input  logic          rst_in,
    fetch_queue_if.slave  fq
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned COUNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENQ_C_W = $clog2(ENQ_WIDTH + 1);

    logic [INSTRUCTION_WIDTH-1:0]                mem_instr [DEPTH];
    logic [63:0]                                 mem_pc    [DEPTH];
    logic [PTR_W-1:0]                            head_q, tail_q, rd_idx;
    logic [COUNT_W-1:0]                          count_q, count_d, eff_take;
    logic                                        overflow_q;
    logic                                        enq_ready, enq_fire, enq_blocked;
    logic [ENQ_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] cmp_instr;
    logic [ENQ_WIDTH-1:0][63:0]                  cmp_pc;
    logic [ENQ_C_W-1:0]                          cmp_count;

    fq_compact #(
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
        .ENQ_WIDTH         (ENQ_WIDTH)
    ) u_compact (
        .mask_in   (fq.enq_mask_in),
        .instr_in  (fq.enq_instr_in),
        .pc_in     (fq.enq_pc_in),
        .instr_out (cmp_instr),
        .pc_out    (cmp_pc),
        .count_out (cmp_count)
    );

    // Readiness looks only at the registered count, so deq_take_in never reaches enq_ready_out.
    assign enq_ready   = count_q <= COUNT_W'(DEPTH - ENQ_WIDTH);
    assign enq_fire    = fq.enq_valid_in & enq_ready & ~fq.flush_in;
    assign enq_blocked = fq.enq_valid_in & ~enq_ready & ~fq.flush_in;
    assign eff_take    = COUNT_W'(fq_min3(32'(fq.deq_take_in), 32'(count_q), DEQ_WIDTH));

    always_comb begin
        count_d = count_q - eff_take;
        if (enq_fire) count_d = count_d + COUNT_W'(cmp_count);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (fq.flush_in) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_q + PTR_W'(eff_take);
                if (enq_fire) tail_q <= tail_q + PTR_W'(cmp_count);
                count_q <= count_d;
            end
            if (enq_blocked) overflow_q <= 1'b1;
        end
    end

    // Payload storage is not reset; only lanes below count are ever presented.
    always_ff @(posedge clk_in) begin
        if (enq_fire) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (ENQ_C_W'(i) < cmp_count) begin
                    mem_instr[tail_q + PTR_W'(i)] <= cmp_instr[i];
                    mem_pc[tail_q + PTR_W'(i)]    <= cmp_pc[i];
                end
            end
        end
    end

    always_comb begin
        rd_idx           = '0;
        fq.deq_valid_out = '0;
        fq.deq_instr_out = '0;
        fq.deq_pc_out    = '0;
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            rd_idx = head_q + PTR_W'(k);
            if (count_q > COUNT_W'(k)) begin
                fq.deq_valid_out[k] = 1'b1;
                fq.deq_instr_out[k] = mem_instr[rd_idx];
                fq.deq_pc_out[k]    = mem_pc[rd_idx];
            end
        end
    end

    assign fq.enq_ready_out    = enq_ready;
    assign fq.count_out        = count_q;
    assign fq.overflow_err_out = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed enqueue/dequeue/flush/reset vectors.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned IW = 32;
    localparam int unsigned EW = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned D  = 16;

    logic clk = 1'b0;
    logic rst;
    bit   mon_en;
    bit   exp_ovf;
    int   n_cmp;
    int   n_fail;
    fq_entry_t exp_q[$];

    always #5 clk = ~clk;

    fetch_queue_if #(
        .INSTRUCTION_WIDTH (IW),
        .ENQ_WIDTH         (EW),
        .DEQ_WIDTH         (DW),
        .DEPTH             (D)
    ) fq ();

    fetch_queue #(
        .INSTRUCTION_WIDTH (IW),
        .ENQ_WIDTH         (EW),
        .DEQ_WIDTH         (DW),
        .DEPTH             (D)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .fq     (fq)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'hF000_0000 | {4'h0, pc[27:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares presented lanes against the scoreboard, then retires what decode takes.
    always @(negedge clk) begin : monitor
        int n;
        int t;
        if (!rst && mon_en) begin
            n = exp_q.size();
            check("enq_ready", 64'(fq.enq_ready_out), 64'(n <= int'(D - EW)));
            check("count", 64'(fq.count_out), 64'(n));
            check("overflow", 64'(fq.overflow_err_out), 64'(exp_ovf));
            for (int k = 0; k < int'(DW); k++) begin
                if (k < n) begin
                    check($sformatf("valid%0d", k), 64'(fq.deq_valid_out[k]), 64'(1));
                    check($sformatf("instr%0d", k), 64'(fq.deq_instr_out[k]), 64'(exp_q[k].instr));
                    check($sformatf("pc%0d", k), fq.deq_pc_out[k], exp_q[k].pc);
                end else begin
                    check($sformatf("valid%0d", k), 64'(fq.deq_valid_out[k]), 64'(0));
                    check($sformatf("instr%0d_zero", k), 64'(fq.deq_instr_out[k]), 64'(0));
                    check($sformatf("pc%0d_zero", k), fq.deq_pc_out[k], 64'(0));
                end
            end
            if (!fq.flush_in) begin
                t = int'(fq.deq_take_in);
                if (t > n) t = n;
                if (t > int'(DW)) t = DW;
                repeat (t) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input bit flush, input bit valid, input logic [3:0] mask,
                         input logic [63:0] pc, input int take);
        fq.flush_in     = flush;
        fq.enq_valid_in = valid;
        fq.enq_mask_in  = mask;
        fq.enq_pc_in    = pc;
        for (int i = 0; i < int'(EW); i++) fq.enq_instr_in[i] = instr_of(pc + 64'(4 * i));
        fq.deq_take_in  = 3'(take);
    endtask

    // One cycle of stimulus; expected entries enter the scoreboard once the edge has taken them.
    task automatic step(input bit flush, input bit valid, input logic [3:0] mask,
                        input logic [63:0] pc, input int take);
        bit ready;
        bit fire;
        ready = exp_q.size() <= int'(D - EW);
        fire  = valid && ready && !flush;
        drive(flush, valid, mask, pc, take);
        @(posedge clk);
        if (flush) exp_q.delete();
        else if (fire) begin
            for (int i = 0; i < int'(EW); i++) begin
                if (mask[i]) exp_q.push_back('{instr: instr_of(pc + 64'(4 * i)),
                                               pc: pc + 64'(4 * i)});
            end
        end
        if (valid && !ready && !flush) exp_ovf = 1'b1;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 64'(fq.count_out), 64'(0));
        check({tag, "_valid"}, 64'(fq.deq_valid_out), 64'(0));
        check({tag, "_ready"}, 64'(fq.enq_ready_out), 64'(1));
        check({tag, "_ovf"}, 64'(fq.overflow_err_out), 64'(0));
        for (int k = 0; k < int'(DW); k++) begin
            check($sformatf("%s_instr%0d", tag, k), 64'(fq.deq_instr_out[k]), 64'(0));
            check($sformatf("%s_pc%0d", tag, k), fq.deq_pc_out[k], 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        exp_ovf = 1'b0;
        mon_en  = 1'b0;
        rst     = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 64'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst    = 1'b0;
        mon_en = 1'b1;
        step(1'b0, 1'b0, 4'h0, 64'h0, 0);

        // Compacted enqueue: slots 1 and 3 become lanes 0 and 1.
        step(1'b0, 1'b1, 4'b1010, 64'h1000, 0);
        check("cmp_count", 64'(fq.count_out), 64'd2);
        check("cmp_valid", 64'(fq.deq_valid_out), 64'b0011);
        check("cmp_instr0", 64'(fq.deq_instr_out[0]), 64'hF000_1004);
        check("cmp_pc0", fq.deq_pc_out[0], 64'h1004);
        check("cmp_instr1", 64'(fq.deq_instr_out[1]), 64'hF000_100C);
        check("cmp_pc1", fq.deq_pc_out[1], 64'h100C);
        step(1'b0, 1'b0, 4'h0, 64'h0, 4);

        // Fill to DEPTH, then a blocked enqueue sets the sticky error.
        for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 4'hF, 64'h3000 + 64'(16 * j), 0);
        check("fill_count", 64'(fq.count_out), 64'd16);
        check("fill_ready", 64'(fq.enq_ready_out), 64'd0);
        step(1'b0, 1'b1, 4'hF, 64'h3100, 0);
        check("ovf_set", 64'(fq.overflow_err_out), 64'd1);
        check("ovf_count", 64'(fq.count_out), 64'd16);
        step(1'b1, 1'b0, 4'h0, 64'h0, 0);
        check("ovf_after_flush", 64'(fq.overflow_err_out), 64'd1);
        check("flush_count", 64'(fq.count_out), 64'd0);

        // Wrap: park head/tail at 14 so later groups straddle 15 -> 0.
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 4'hF, 64'h2000 + 64'(16 * j), 0);
        step(1'b0, 1'b1, 4'b0011, 64'h2030, 0);
        check("wrap_count14", 64'(fq.count_out), 64'd14);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 4'h0, 64'h0, 4);
        check("wrap_empty", 64'(fq.count_out), 64'd0);
        step(1'b0, 1'b1, 4'hF, 64'h2100, 4);
        check("wrap_pc2", fq.deq_pc_out[2], 64'h2108);
        check("wrap_pc3", fq.deq_pc_out[3], 64'h210C);
        step(1'b0, 1'b1, 4'hF, 64'h2110, 4);
        check("wrap_lane0", fq.deq_pc_out[0], 64'h2110);
        check("wrap_count4", 64'(fq.count_out), 64'd4);
        step(1'b0, 1'b0, 4'h0, 64'h0, 4);
        check("wrap_drained", 64'(fq.count_out), 64'd0);

        // Over-take clamps while a full group enters.
        step(1'b0, 1'b1, 4'b0011, 64'h4000, 0);
        step(1'b0, 1'b1, 4'hF, 64'h5000, 4);
        check("otake_count", 64'(fq.count_out), 64'd4);
        check("otake_pc0", fq.deq_pc_out[0], 64'h5000);
        check("otake_instr0", 64'(fq.deq_instr_out[0]), 64'hF000_5000);
        step(1'b0, 1'b0, 4'h0, 64'h0, 4);

        // Flush beats concurrent enqueue and dequeue.
        step(1'b0, 1'b1, 4'hF, 64'h6000, 0);
        step(1'b0, 1'b1, 4'hF, 64'h6010, 0);
        step(1'b0, 1'b1, 4'b0001, 64'h6020, 0);
        check("pre_flush_count", 64'(fq.count_out), 64'd9);
        step(1'b1, 1'b1, 4'hF, 64'h6100, 3);
        check("fl_count", 64'(fq.count_out), 64'd0);
        check("fl_valid", 64'(fq.deq_valid_out), 64'd0);
        check("fl_ready", 64'(fq.enq_ready_out), 64'd1);

        // Asynchronous reset in the middle of a burst.
        step(1'b0, 1'b1, 4'hF, 64'h7000, 0);
        drive(1'b0, 1'b1, 4'hF, 64'h7100, 2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        exp_q.delete();
        exp_ovf = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 64'h0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 4'h0, 64'h0, 0);
        step(1'b0, 1'b1, 4'b1100, 64'h8000, 0);
        check("post_rst_pc0", fq.deq_pc_out[0], 64'h8008);
        step(1'b0, 1'b0, 4'h0, 64'h0, 4);
        step(1'b0, 1'b0, 4'h0, 64'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
